// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit. A single Moore/Mealy FSM walks each
// instruction through fetch, decode, execute, memory and writeback, and
// drives every datapath select and enable. MIO_ready stalls the fetch and
// data-memory states until the bus transfer completes.
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtSel,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic [2:0]  ALU_operation,
  output logic [3:0]  state_out
);

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_IF    = 4'd1;
  localparam logic [3:0] S_ID    = 4'd2;
  localparam logic [3:0] S_MA    = 4'd3;
  localparam logic [3:0] S_MRD   = 4'd4;
  localparam logic [3:0] S_WB_LW = 4'd5;
  localparam logic [3:0] S_MWR   = 4'd6;
  localparam logic [3:0] S_EX_R  = 4'd7;
  localparam logic [3:0] S_WB_R  = 4'd8;
  localparam logic [3:0] S_EX_I  = 4'd9;
  localparam logic [3:0] S_WB_I  = 4'd10;
  localparam logic [3:0] S_BR    = 4'd11;
  localparam logic [3:0] S_J     = 4'd12;
  localparam logic [3:0] S_JAL   = 4'd13;
  localparam logic [3:0] S_JR    = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b011;

  logic [3:0] state_q, state_d;
  logic [5:0] opcode, funct;
  logic       r_funct_ok;
  logic [2:0] r_alu_op;
  logic       unused_inst;

  assign opcode      = Inst_in[31:26];
  assign funct       = Inst_in[5:0];
  assign unused_inst = ^Inst_in[25:6];

  // R-type funct decode: ALU operation and whether the funct is supported
  always_comb begin
    r_funct_ok = 1'b1;
    r_alu_op   = ALU_ADD;
    case (funct)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b100110: r_alu_op = ALU_XOR;
      6'b100111: r_alu_op = ALU_NOR;
      6'b101010: r_alu_op = ALU_SLT;
      default:   r_funct_ok = 1'b0;
    endcase
  end

  // State register with asynchronous reset to RST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF:  state_d = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MA;
          OP_RTYPE:                          state_d = (funct == FN_JR) ? S_JR : S_EX_R;
          OP_BEQ, OP_BNE:                    state_d = S_BR;
          OP_J:                              state_d = S_J;
          OP_JAL:                            state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EX_I;
          default:                           state_d = S_IF;
        endcase
      end
      S_MA:    state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = MIO_ready ? S_WB_LW : S_MRD;
      S_MWR:   state_d = MIO_ready ? S_IF : S_MWR;
      S_EX_R:  state_d = r_funct_ok ? S_WB_R : S_IF;
      S_EX_I:  state_d = S_WB_I;
      default: state_d = S_IF;
    endcase
  end

  // Output decode from current state and live inputs
  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ExtSel        = 1'b0;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    ALU_operation = ALU_ADD;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID: ALUSrcB = 2'b11;
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LW: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EX_R: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_alu_op;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_EX_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtSel  = (opcode == OP_ANDI) || (opcode == OP_ORI);
        case (opcode)
          OP_SLTI: ALU_operation = ALU_SLT;
          OP_ANDI: ALU_operation = ALU_AND;
          OP_ORI:  ALU_operation = ALU_OR;
          default: ALU_operation = ALU_ADD;
        endcase
      end
      S_WB_I: RegWrite = 1'b1;
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = 2'b01;
        PCWrite       = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_J: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_JAL: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_JR: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
      default: ALU_operation = 3'b000;
    endcase
  end

  assign CPU_MIO   = MemRead | MemWrite;
  assign state_out = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a table of per-cycle input/expected-output
// records plus a hand-written asynchronous reset sequence.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Inst_in = 32'h0;
  logic        zero = 1'b0;
  logic        MIO_ready = 1'b0;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic        ALUSrcA, ExtSel, PCWrite;
  logic [2:0]  ALU_operation;
  logic [3:0]  state_out;

  int n_cmp = 0;
  int n_bad = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .MIO_ready(MIO_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .PCSource(PCSource),
    .PCWrite(PCWrite), .ALU_operation(ALU_operation), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] inst;
    logic        z;
    logic        mio;
    logic [3:0]  st;
    logic [19:0] outs;
  } vec_t;

  vec_t vq[$];

  // Expected control word; CPU_MIO is the OR of the two memory requests.
  function automatic logic [19:0] mk(int mr, int mw, int iord, int irw, int rw, int rdst,
                                     int m2r, int asa, int asb, int ext, int pcs, int pcw,
                                     int alu);
    return {1'(mr), 1'(mw), 1'(mr | mw), 1'(iord), 1'(irw), 1'(rw), 2'(rdst), 2'(m2r),
            1'(asa), 2'(asb), 1'(ext), 2'(pcs), 1'(pcw), 3'(alu)};
  endfunction

  function automatic logic [19:0] dut_outs();
    return {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, ExtSel, PCSource, PCWrite, ALU_operation};
  endfunction

  task automatic add(input string tag, input logic r, input logic [31:0] inst, input logic z,
                     input logic mio, input logic [3:0] st, input logic [19:0] o);
    vec_t v;
    v.tag = tag; v.rst = r; v.inst = inst; v.z = z; v.mio = mio; v.st = st; v.outs = o;
    vq.push_back(v);
  endtask

  task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got state/ctl %h, expected %h", tag, act, exp);
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_LW   = 32'h8C040008;
  localparam logic [31:0] I_SW   = 32'hAC040008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_ORI  = 32'h34A5FFFF;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_JR   = 32'h03E00008;

  initial begin
    logic [19:0] z0, if1, if0, idp, wbr, ma, mrd, wblw, mwr, wbi;
    z0   = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
    if1  = mk(1,0,0,1,0,0,0,0,1,0,0,1,2);
    if0  = mk(1,0,0,0,0,0,0,0,1,0,0,0,2);
    idp  = mk(0,0,0,0,0,0,0,0,3,0,0,0,2);
    wbr  = mk(0,0,0,0,1,1,0,0,0,0,0,0,2);
    ma   = mk(0,0,0,0,0,0,0,1,2,0,0,0,2);
    mrd  = mk(1,0,1,0,0,0,0,0,0,0,0,0,2);
    wblw = mk(0,0,0,0,1,0,1,0,0,0,0,0,2);
    mwr  = mk(0,1,1,0,0,0,0,0,0,0,0,0,2);
    wbi  = mk(0,0,0,0,1,0,0,0,0,0,0,0,2);

    add("rst_hold",  1, I_ADD, 0, 1, 0,  z0);
    add("rst_rel",   0, I_ADD, 0, 1, 0,  z0);
    add("add_if",    0, I_ADD, 0, 1, 1,  if1);
    add("add_id",    0, I_ADD, 0, 1, 2,  idp);
    add("add_ex",    0, I_ADD, 0, 1, 7,  mk(0,0,0,0,0,0,0,1,0,0,0,0,2));
    add("add_wb",    0, I_ADD, 0, 1, 8,  wbr);
    add("sub_if",    0, I_SUB, 0, 1, 1,  if1);
    add("sub_id",    0, I_SUB, 0, 1, 2,  idp);
    add("sub_ex",    0, I_SUB, 0, 1, 7,  mk(0,0,0,0,0,0,0,1,0,0,0,0,6));
    add("sub_wb",    0, I_SUB, 0, 1, 8,  wbr);
    add("lw_if",     0, I_LW,  0, 1, 1,  if1);
    add("lw_id",     0, I_LW,  0, 1, 2,  idp);
    add("lw_ma",     0, I_LW,  0, 1, 3,  ma);
    add("lw_mrd0",   0, I_LW,  0, 0, 4,  mrd);
    add("lw_mrd1",   0, I_LW,  0, 0, 4,  mrd);
    add("lw_mrd2",   0, I_LW,  0, 0, 4,  mrd);
    add("lw_mrd3",   0, I_LW,  0, 1, 4,  mrd);
    add("lw_wb",     0, I_LW,  0, 1, 5,  wblw);
    add("sw_if",     0, I_SW,  0, 1, 1,  if1);
    add("sw_id",     0, I_SW,  0, 1, 2,  idp);
    add("sw_ma",     0, I_SW,  0, 1, 3,  ma);
    add("sw_mwr",    0, I_SW,  0, 1, 6,  mwr);
    add("beq1_if",   0, I_BEQ, 1, 1, 1,  if1);
    add("beq1_id",   0, I_BEQ, 1, 1, 2,  idp);
    add("beq1_br",   0, I_BEQ, 1, 1, 11, mk(0,0,0,0,0,0,0,1,0,0,1,1,6));
    add("beq0_if",   0, I_BEQ, 0, 1, 1,  if1);
    add("beq0_id",   0, I_BEQ, 0, 1, 2,  idp);
    add("beq0_br",   0, I_BEQ, 0, 1, 11, mk(0,0,0,0,0,0,0,1,0,0,1,0,6));
    add("bne1_if",   0, I_BNE, 1, 1, 1,  if1);
    add("bne1_id",   0, I_BNE, 1, 1, 2,  idp);
    add("bne1_br",   0, I_BNE, 1, 1, 11, mk(0,0,0,0,0,0,0,1,0,0,1,0,6));
    add("bne0_if",   0, I_BNE, 0, 1, 1,  if1);
    add("bne0_id",   0, I_BNE, 0, 1, 2,  idp);
    add("bne0_br",   0, I_BNE, 0, 1, 11, mk(0,0,0,0,0,0,0,1,0,0,1,1,6));
    add("jal_if",    0, I_JAL, 0, 1, 1,  if1);
    add("jal_id",    0, I_JAL, 0, 1, 2,  idp);
    add("jal_ex",    0, I_JAL, 0, 1, 13, mk(0,0,0,0,1,2,2,0,0,0,2,1,2));
    add("ori_if",    0, I_ORI, 0, 1, 1,  if1);
    add("ori_id",    0, I_ORI, 0, 1, 2,  idp);
    add("ori_ex",    0, I_ORI, 0, 1, 9,  mk(0,0,0,0,0,0,0,1,2,1,0,0,1));
    add("ori_wb",    0, I_ORI, 0, 1, 10, wbi);
    add("addu_if",   0, I_ADDU,0, 1, 1,  if1);
    add("addu_id",   0, I_ADDU,0, 1, 2,  idp);
    add("addu_ex",   0, I_ADDU,0, 1, 7,  mk(0,0,0,0,0,0,0,1,0,0,0,0,2));
    add("bad_if",    0, I_BAD, 0, 1, 1,  if1);
    add("bad_id",    0, I_BAD, 0, 1, 2,  idp);
    for (int k = 0; k < 5; k++) add("if_stall", 0, I_BAD, 0, 0, 1, if0);
    add("if_go",     0, I_JR,  0, 1, 1,  if1);
    add("jr_id",     0, I_JR,  0, 1, 2,  idp);
    add("jr_ex",     0, I_JR,  0, 1, 14, mk(0,0,0,0,0,0,0,0,0,0,3,1,2));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset     = vq[i].rst;
      Inst_in   = vq[i].inst;
      zero      = vq[i].z;
      MIO_ready = vq[i].mio;
      #1;
      check(vq[i].tag, {state_out, dut_outs()}, {vq[i].st, vq[i].outs});
    end

    // Asynchronous reset while a load is waiting in MRD
    @(negedge clk); Inst_in = I_LW; MIO_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); MIO_ready = 1'b0;
    #1 check("mrd_before_rst", {state_out, dut_outs()}, {4'd4, mrd});
    #2 reset = 1'b1;
    #1 check("async_rst", {state_out, dut_outs()}, {4'd0, z0});
    @(negedge clk); reset = 1'b0; MIO_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_to_if", {state_out, dut_outs()}, {4'd1, if1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
